// File: rtl/aurora_pkg.sv
// ============================================================================
// Module   : aurora_pkg
// Brief    : Shared types and default widths for the data-memory subsystem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aurora_pkg;

  // Default data memory geometry, shared with the memory macro wrapper
  localparam int c_ADDR_W = 8;
  localparam int c_DATA_W = 16;

  // Arbiter operating mode
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Owner of the read whose data returns in the current cycle
  typedef enum logic [1:0] {
    NONE = 2'd0,
    PIPE = 2'd1,
    HOST = 2'd2
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Pipeline, host and memory-side bus of the data memory arbiter.
//            Signal suffixes are relative to the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
  parameter int ADDR_W = aurora_pkg::c_ADDR_W,
  parameter int DATA_W = aurora_pkg::c_DATA_W
);

  // Pipeline MEM stage side
  logic              pipe_req_i;
  logic              pipe_we_i;
  logic [ADDR_W-1:0] pipe_addr_i;
  logic [DATA_W-1:0] pipe_wdata_i;
  logic              pipe_stall_o;
  logic [DATA_W-1:0] pipe_rdata_o;
  logic              pipe_rvalid_o;

  // Host / debug side
  logic              host_req_i;
  logic              host_we_i;
  logic [ADDR_W-1:0] host_addr_i;
  logic [DATA_W-1:0] host_wdata_i;
  logic              host_lock_i;
  logic              host_gnt_o;
  logic              host_locked_o;
  logic [DATA_W-1:0] host_rdata_o;
  logic              host_rvalid_o;

  // Data memory macro side
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  // Arbiter view
  modport slave (
    input  pipe_req_i, pipe_we_i, pipe_addr_i, pipe_wdata_i,
    output pipe_stall_o, pipe_rdata_o, pipe_rvalid_o,
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_lock_i,
    output host_gnt_o, host_locked_o, host_rdata_o, host_rvalid_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // Requester / memory view
  modport master (
    output pipe_req_i, pipe_we_i, pipe_addr_i, pipe_wdata_i,
    input  pipe_stall_o, pipe_rdata_o, pipe_rvalid_o,
    output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_lock_i,
    input  host_gnt_o, host_locked_o, host_rdata_o, host_rvalid_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Single-port data memory arbiter between the pipeline MEM stage
//            and the host/debug port, with starvation guard, exclusive host
//            lock and one-cycle read data return routing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import aurora_pkg::*;
#(
  parameter int ADDR_W       = c_ADDR_W,
  parameter int DATA_W       = c_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  wire           clk_i,
  input  wire           rst_ni,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t        r_state, w_state_nxt;
  owner_t            r_rd_owner, w_rd_owner_nxt;
  logic [3:0]        r_starve_cnt, w_starve_nxt;
  logic              r_host_locked;
  logic [DATA_W-1:0] r_pipe_rdata, r_host_rdata;
  logic              w_pipe_gnt, w_host_gnt;
  logic              w_pipe_rvalid, w_host_rvalid;

  // Grant selection; nothing is granted while reset is asserted so every
  // output reads zero during reset.
  always_comb begin
    w_pipe_gnt = 1'b0;
    w_host_gnt = 1'b0;
    if (rst_ni) begin
      case (r_state)
        RUN: begin
          if (bus.host_req_i && (r_starve_cnt == c_STARVE_MAX || !bus.pipe_req_i))
            w_host_gnt = 1'b1;
          else if (bus.pipe_req_i)
            w_pipe_gnt = 1'b1;
        end
        default: w_host_gnt = bus.host_req_i;
      endcase
    end
  end

  // Next mode: drain outstanding pipeline reads before locking, and hold the
  // lock until the last host read has returned.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (bus.host_lock_i) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!bus.host_lock_i)        w_state_nxt = RUN;
        else if (r_rd_owner != PIPE) w_state_nxt = LOCKED;
      end
      LOCKED: begin
        if (!bus.host_lock_i && r_rd_owner != HOST) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Read owner for next cycle's data return and saturating starvation count
  always_comb begin
    w_rd_owner_nxt = NONE;
    if (w_pipe_gnt && !bus.pipe_we_i)      w_rd_owner_nxt = PIPE;
    else if (w_host_gnt && !bus.host_we_i) w_rd_owner_nxt = HOST;

    w_starve_nxt = r_starve_cnt;
    if (!bus.host_req_i || w_host_gnt)  w_starve_nxt = 4'd0;
    else if (r_starve_cnt != c_STARVE_MAX) w_starve_nxt = r_starve_cnt + 4'd1;
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= RUN;
      r_rd_owner    <= NONE;
      r_starve_cnt  <= 4'd0;
      r_host_locked <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd_owner    <= w_rd_owner_nxt;
      r_starve_cnt  <= w_starve_nxt;
      r_host_locked <= (w_state_nxt == LOCKED);
    end
  end

  // Keep the last returned word per requester so rdata holds between returns
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pipe_rdata <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_pipe_rvalid) r_pipe_rdata <= bus.mem_rdata_i;
      if (w_host_rvalid) r_host_rdata <= bus.mem_rdata_i;
    end
  end

  assign w_pipe_rvalid = (r_rd_owner == PIPE);
  assign w_host_rvalid = (r_rd_owner == HOST);

  assign bus.pipe_stall_o  = rst_ni & bus.pipe_req_i & ~w_pipe_gnt;
  assign bus.pipe_rvalid_o = w_pipe_rvalid;
  assign bus.pipe_rdata_o  = w_pipe_rvalid ? bus.mem_rdata_i : r_pipe_rdata;

  assign bus.host_gnt_o    = w_host_gnt;
  assign bus.host_locked_o = r_host_locked;
  assign bus.host_rvalid_o = w_host_rvalid;
  assign bus.host_rdata_o  = w_host_rvalid ? bus.mem_rdata_i : r_host_rdata;

  assign bus.mem_en_o    = w_pipe_gnt | w_host_gnt;
  assign bus.mem_we_o    = (w_pipe_gnt & bus.pipe_we_i) | (w_host_gnt & bus.host_we_i);
  assign bus.mem_addr_o  = w_pipe_gnt ? bus.pipe_addr_i :
                           w_host_gnt ? bus.host_addr_i : '0;
  assign bus.mem_wdata_o = w_pipe_gnt ? bus.pipe_wdata_i :
                           w_host_gnt ? bus.host_wdata_i : '0;

endmodule

`default_nettype wire
